pc_unit: RTL and testbench

// - Parametrised program-counter unit for the IF stage; generalises the 8-bit PC register.
// - Holds the current PC and selects the next one from: sequential increment, stall hold,

---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/pc_unit_ras_stack.sv | 51 +++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared defaults and the next-PC source encoding for the IF-stage PC unit.
package pc_unit_pkg;

    localparam int unsigned PC_W_DEF      = 8;
    localparam int unsigned STEP_DEF      = 1;
    localparam int unsigned RESET_VEC_DEF = 0;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_REDIR,
        SRC_JUMP,
        SRC_RET
    } pc_src_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;    // next write slot; top lives at ptr-1
    logic [CW-1:0] count;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;
    assign ovf    = push & ~pop & full;
    assign unf    = pop & empty;
    assign top    = mem[ptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            mem[ptr - PW'(1)] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: prioritised next-PC select, PC register and RAS error pulse.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned STEP      = STEP_DEF,
    parameter int unsigned RESET_VEC = RESET_VEC_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            jump_valid,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jump_link,
    input  logic            ret_valid,
    output logic [PC_W-1:0] currentPC,
    output logic [PC_W-1:0] seqPC,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    pc_src_e         src;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_ovf;
    logic            ras_unf;
    logic            err_d;

    assign seqPC = currentPC + PC_W'(STEP);

    always_comb begin
        if (redirect_valid) begin
            src = SRC_REDIR;
        end else if (stall) begin
            src = SRC_HOLD;
        end else if (jump_valid) begin
            src = SRC_JUMP;
        end else if (ret_valid) begin
            src = SRC_RET;
        end else begin
            src = SRC_SEQ;
        end
    end

    assign ras_push = (src == SRC_JUMP) & jump_link;
    assign ras_pop  = (src == SRC_RET);

    always_comb begin
        next_pc = seqPC;
        unique case (src)
            SRC_REDIR: next_pc = redirect_target;
            SRC_HOLD:  next_pc = currentPC;
            SRC_JUMP:  next_pc = jump_target;
            SRC_RET:   next_pc = ras_empty ? seqPC : ras_top;
            default:   next_pc = seqPC;
        endcase
    end

    // A ret that loses to a same-cycle jump is dropped and flagged.
    assign err_d = ras_ovf | ras_unf | ((src == SRC_JUMP) & ret_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            currentPC <= PC_W'(RESET_VEC);
            ras_err   <= 1'b0;
        end else begin
            currentPC <= next_pc;
            ras_err   <= err_d;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seqPC),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based PC/RAS model predicts each cycle's outputs.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       jump_valid = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic       jump_link = 1'b0;
    logic       ret_valid = 1'b0;
    logic [7:0] currentPC;
    logic [7:0] seqPC;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_err;

    typedef struct {
        logic [7:0] pc;
        logic       err;
        logic       empty;
        logic       full;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_ras[$];
    logic [7:0] m_pc = 8'h00;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_W      (8),
        .STEP      (1),
        .RESET_VEC (0),
        .RAS_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .jump_valid      (jump_valid),
        .jump_target     (jump_target),
        .jump_link       (jump_link),
        .ret_valid       (ret_valid),
        .currentPC       (currentPC),
        .seqPC           (seqPC),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ras_err         (ras_err)
    );

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endfunction

    // Drive one cycle of control and predict the state after the next rising edge.
    task automatic step(input logic r, input logic s, input logic rv, input logic [7:0] rt,
                        input logic jv, input logic [7:0] jt, input logic jl, input logic rtv);
        exp_t e;
        int   seq;
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
        jump_valid = jv; jump_target = jt; jump_link = jl; ret_valid = rtv;
        seq   = (int'(m_pc) + 1) % 256;
        e.err = 1'b0;
        if (r) begin
            m_pc = 8'h00;
            m_ras.delete();
        end else if (rv) begin
            m_pc = rt;
        end else if (s) begin
            m_pc = m_pc;
        end else if (jv) begin
            e.err = rtv;
            if (jl) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    e.err = 1'b1;
                end
                m_ras.push_back(8'(seq));
            end
            m_pc = jt;
        end else if (rtv) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = 8'(seq);
                e.err = 1'b1;
            end
        end else begin
            m_pc = 8'(seq);
        end
        e.pc    = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == 4);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [7:0] t);
        step(1'b0, 1'b0, 1'b1, t, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic call(input logic [7:0] t);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, t, 1'b1, 1'b0);
    endtask

    task automatic ret();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Monitor: every edge presents a new PC; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("currentPC", int'(currentPC), int'(e.pc));
                chk("seqPC", int'(seqPC), (int'(e.pc) + 1) % 256);
                chk("ras_err", int'(ras_err), int'(e.err));
                chk("ras_empty", int'(ras_empty), int'(e.empty));
                chk("ras_full", int'(ras_full), int'(e.full));
            end
        end
    end

    initial begin
        // Reset then free-running count 0..5
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) idle();
        // Wrap from 0xFF
        redir(8'hFF);
        idle();
        // Stall blocks jumps; redirect overrides stall
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
        // Nested calls and returns
        redir(8'h10);
        call(8'h50);
        idle();
        idle();
        call(8'h70);
        ret();
        ret();
        // Underflow
        redir(8'h20);
        ret();
        idle();
        // Overflow drops the oldest, then four LIFO pops
        for (int i = 0; i < 5; i++) call(8'(8'h90 + 8'(i * 16)));
        repeat (4) ret();
        idle();
        // Jump and ret together
        call(8'h60);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b1);
        idle();
        // Reset during a call
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0, 1'b1, 1'b0);
        idle();
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0,
                 8'($urandom),
                 $urandom_range(0, 3) == 0,
                 8'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
